// File: rtl/spi_sram_bridge.sv
// spi_sram_bridge: serves single-byte core read/write requests from a 23LC-style SPI SRAM
// using one mode-0 frame {opcode, address, data} per request.
module spi_sram_bridge #(
    parameter int         ADDR_W    = 16,
    parameter int         DIV       = 1,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_wdata,
    output logic              req_ready,
    output logic              busy,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              spi_cs_n,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);
    localparam int N  = 16 + ADDR_W;
    localparam int BW = $clog2(N);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);
    localparam logic [BW-1:0] RD_FIRST = BW'(N - 8);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    frame_q, frame_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DW-1:0]   div_q, div_d;
    logic            phase_q, phase_d;
    logic            write_q, write_d;
    logic [7:0]      rd_q, rd_d;
    logic [7:0]      rsp_q, rsp_d;
    logic            half_end, bit_end;

    assign half_end = div_q == DIV_LAST;
    assign bit_end  = phase_q && half_end;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            frame_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            phase_q <= 1'b0;
            write_q <= 1'b0;
            rd_q    <= '0;
            rsp_q   <= '0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            phase_q <= phase_d;
            write_q <= write_d;
            rd_q    <= rd_d;
            rsp_q   <= rsp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        bit_d   = bit_q;
        div_d   = div_q;
        phase_d = phase_q;
        write_d = write_q;
        rd_d    = rd_q;
        rsp_d   = rsp_q;
        unique case (state_q)
            IDLE: begin
                bit_d   = '0;
                div_d   = '0;
                phase_d = 1'b0;
                if (req_valid) begin
                    state_d = SHIFT;
                    write_d = req_write;
                    frame_d = {req_write ? CMD_WRITE : CMD_READ, req_addr, req_write ? req_wdata : 8'h00};
                end
            end
            SHIFT: begin
                div_d   = half_end ? '0 : div_q + 1'b1;
                phase_d = phase_q ^ half_end;
                // MISO is taken on the sclk rising edge, and only during the data byte
                if (phase_q && div_q == '0 && bit_q >= RD_FIRST)
                    rd_d = {rd_q[6:0], spi_miso};
                if (bit_end) begin
                    frame_d = frame_q << 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = DONE;
                        rsp_d   = write_q ? rsp_q : rd_d;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = state_q == IDLE;
    assign busy      = ~req_ready;
    assign rsp_valid = state_q == DONE;
    assign rsp_data  = rsp_q;
    assign spi_cs_n  = state_q != SHIFT;
    assign spi_sclk  = state_q == SHIFT && phase_q;
    assign spi_mosi  = state_q == SHIFT && frame_q[N-1];
endmodule
